// File: rtl/y86_pkg.sv
// Shared Y86 encoding constants used by the instruction-memory writer, fetch and decode.
// Holds instruction codes, instruction byte lengths and the writer's state encoding.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_CMOVXX = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [3:0] LEN_1  = 4'd1;
  localparam logic [3:0] LEN_2  = 4'd2;
  localparam logic [3:0] LEN_9  = 4'd9;
  localparam logic [3:0] LEN_10 = 4'd10;

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_e;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

endpackage

// File: rtl/y86_imem_writer_if.sv
// Instruction-in / byte-write-out bundle of the Y86 instruction-memory writer.
// An instruction transfers on a rising edge where in_valid && in_ready; the master holds the
// fields stable while in_valid is high, and in_ready never depends combinationally on in_valid.
interface y86_imem_writer_if #(
  parameter int ADDR_W = 64
);
  logic              base_load;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        icode;
  logic [3:0]        ifun;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic [63:0]       valC;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              instr_done;
  logic [ADDR_W-1:0] valP;
  logic              in_err;
  logic [ADDR_W-1:0] wptr;
  logic [0:0]        state;

  modport master (
    output base_load, base_addr, in_valid, icode, ifun, rA, rB, valC,
    input  in_ready, mem_we, mem_addr, mem_wdata, instr_done, valP, in_err, wptr, state
  );

  modport slave (
    input  base_load, base_addr, in_valid, icode, ifun, rA, rB, valC,
    output in_ready, mem_we, mem_addr, mem_wdata, instr_done, valP, in_err, wptr, state
  );
endinterface

// File: rtl/y86_instr_len.sv
// Combinational Y86 instruction classifier: byte length, legality and which optional fields
// (register byte, 8-byte constant) the encoding carries.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] i_icode,
  output logic [3:0] o_len,
  output logic       o_valid,
  output logic       o_has_regbyte,
  output logic       o_has_valc
);
  always_comb begin
    o_len         = 4'd0;
    o_valid       = 1'b1;
    o_has_regbyte = 1'b0;
    o_has_valc    = 1'b0;
    case (i_icode)
      ICODE_HALT, ICODE_NOP, ICODE_RET: o_len = LEN_1;
      ICODE_CMOVXX, ICODE_OPQ, ICODE_PUSHQ, ICODE_POPQ: begin
        o_len         = LEN_2;
        o_has_regbyte = 1'b1;
      end
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ: begin
        o_len         = LEN_10;
        o_has_regbyte = 1'b1;
        o_has_valc    = 1'b1;
      end
      ICODE_JXX, ICODE_CALL: begin
        o_len      = LEN_9;
        o_has_valc = 1'b1;
      end
      default: o_valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/y86_imem_writer.sv
// Serializes one decoded Y86 instruction per handshake into byte writes at a running write
// pointer, using the same byte layout (MSB-first valC) that fetch reads back.
module y86_imem_writer
  import y86_pkg::*;
#(
  parameter int                MEM_BYTES  = 1024,
  parameter int                ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input logic             clk,
  input logic             rst_n,
  y86_imem_writer_if.slave bus
);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_wptr, r_valP, r_mem_addr;
  logic              r_mem_we, r_instr_done, r_in_err;
  logic [7:0]        r_mem_wdata;
  logic [3:0]        r_idx, r_len;
  logic              r_has_reg, r_has_valc;
  logic [3:0]        r_icode, r_ifun, r_rA, r_rB;
  logic [63:0]       r_valC;

  logic [3:0]        w_len;
  logic              w_valid, w_has_reg, w_has_valc;
  logic [ADDR_W-1:0] w_start;
  logic [ADDR_W:0]   w_end;
  logic              w_accept_ok;

  y86_instr_len u_len (
    .i_icode       (bus.icode),
    .o_len         (w_len),
    .o_valid       (w_valid),
    .o_has_regbyte (w_has_reg),
    .o_has_valc    (w_has_valc)
  );

  // A same-cycle base_load redirects the instruction being accepted.
  assign w_start     = bus.base_load ? bus.base_addr : r_wptr;
  assign w_end       = {1'b0, w_start} + (ADDR_W+1)'(w_len);
  assign w_accept_ok = w_valid && (w_end <= (ADDR_W+1)'(MEM_BYTES));

  function automatic logic [7:0] f_byte(input logic [3:0] idx, input logic has_reg,
                                        input logic has_valc, input logic [3:0] ic,
                                        input logic [3:0] ifn, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [63:0] vc);
    logic [3:0] j;
    logic [2:0] sel;
    logic [7:0] b;
    b   = 8'h00;
    j   = idx - (has_reg ? 4'd2 : 4'd1);
    sel = 3'(4'd7 - j);
    if (idx == 4'd0)                  b = {ic, ifn};
    else if (has_reg && idx == 4'd1)  b = {ra, rb};
    else if (has_valc && j < 4'd8)    b = vc[{sel, 3'b000} +: 8];
    return b;
  endfunction

  // Byte 0 is registered at the accept edge; r_idx names the byte currently on the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wptr       <= RESET_ADDR;
      r_valP       <= RESET_ADDR;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 8'h00;
      r_instr_done <= 1'b0;
      r_in_err     <= 1'b0;
      r_idx        <= 4'd0;
      r_len        <= 4'd0;
      r_has_reg    <= 1'b0;
      r_has_valc   <= 1'b0;
      r_icode      <= 4'd0;
      r_ifun       <= 4'd0;
      r_rA         <= 4'd0;
      r_rB         <= 4'd0;
      r_valC       <= 64'd0;
    end else begin
      r_instr_done <= 1'b0;
      r_in_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_mem_we <= 1'b0;
          if (bus.base_load) r_wptr <= bus.base_addr;
          if (bus.in_valid) begin
            if (!w_accept_ok) begin
              r_in_err <= 1'b1;
            end else begin
              r_icode     <= bus.icode;
              r_ifun      <= bus.ifun;
              r_rA        <= bus.rA;
              r_rB        <= bus.rB;
              r_valC      <= bus.valC;
              r_len       <= w_len;
              r_has_reg   <= w_has_reg;
              r_has_valc  <= w_has_valc;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= w_start;
              r_mem_wdata <= {bus.icode, bus.ifun};
              r_wptr      <= w_start + ONE;
              r_idx       <= 4'd0;
              r_state     <= ST_EMIT;
              if (w_len == LEN_1) begin
                r_instr_done <= 1'b1;
                r_valP       <= w_start + ONE;
              end
            end
          end
        end
        default: begin
          if (r_idx == r_len - 4'd1) begin
            r_state  <= ST_IDLE;
            r_mem_we <= 1'b0;
          end else begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_wptr;
            r_mem_wdata <= f_byte(r_idx + 4'd1, r_has_reg, r_has_valc,
                                  r_icode, r_ifun, r_rA, r_rB, r_valC);
            r_wptr      <= r_wptr + ONE;
            r_idx       <= r_idx + 4'd1;
            if (r_idx + 4'd2 == r_len) begin
              r_instr_done <= 1'b1;
              r_valP       <= r_wptr + ONE;
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready   = (r_state == ST_IDLE);
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.instr_done = r_instr_done;
  assign bus.valP       = r_valP;
  assign bus.in_err     = r_in_err;
  assign bus.wptr       = r_wptr;
  assign bus.state      = r_state;
endmodule

// File: tb/tb_y86_imem_writer.sv
// Self-checking bench for y86_imem_writer: directed scenarios plus random instruction streams
// compared cycle by cycle against a byte-image reference model.
module tb_y86_imem_writer;
  import y86_pkg::*;

  localparam int MEM_BYTES = 1024;
  localparam int ADDR_W    = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  y86_imem_writer_if #(.ADDR_W(ADDR_W)) bus();

  y86_imem_writer #(
    .MEM_BYTES  (MEM_BYTES),
    .ADDR_W     (ADDR_W),
    .RESET_ADDR (64'd0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [71:0] exp_q[$];
  logic [63:0] m_wptr;
  logic [63:0] m_valp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h3, 4'h4, 4'h5:       return 10;
      4'h7, 4'h8:             return 9;
      default:                return 0;
    endcase
  endfunction

  // Reference image: build the whole instruction, then queue (address, byte) pairs.
  task automatic model_image(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                             input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] start);
    logic [7:0] img[10];
    int n;
    n = ref_len(ic);
    for (int i = 0; i < 10; i++) img[i] = 8'h00;
    img[0] = {ic, ifn};
    if (n == 2 || n == 10) img[1] = {ra, rb};
    if (n == 10) for (int i = 0; i < 8; i++) img[2+i] = 8'(vc >> (8 * (7 - i)));
    if (n == 9)  for (int i = 0; i < 8; i++) img[1+i] = 8'(vc >> (8 * (7 - i)));
    for (int k = 0; k < n; k++) exp_q.push_back({start + 64'(k), img[k]});
  endtask

  task automatic clear_inputs();
    bus.in_valid  = 1'b0;
    bus.base_load = 1'b0;
    bus.base_addr = 64'd0;
    bus.icode     = 4'd0;
    bus.ifun      = 4'd0;
    bus.rA        = 4'd0;
    bus.rB        = 4'd0;
    bus.valC      = 64'd0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic send(input logic [3:0] ic, input logic [3:0] ifn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc, input logic bl,
                      input logic [63:0] ba, input logic noise);
    logic [63:0] start;
    logic [71:0] e;
    logic [64:0] fin;
    int n;
    bit ok;
    n     = ref_len(ic);
    start = bl ? ba : m_wptr;
    fin   = {1'b0, start} + 65'(n);
    ok    = (n != 0) && (fin <= 65'(MEM_BYTES));
    if (bl) m_wptr = ba;
    bus.icode = ic; bus.ifun = ifn; bus.rA = ra; bus.rB = rb; bus.valC = vc;
    bus.base_load = bl; bus.base_addr = ba; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 clear_inputs();
    if (!ok) begin
      @(negedge clk);
      check("err_pulse", 64'(bus.in_err), 64'd1);
      check("err_no_we", 64'(bus.mem_we), 64'd0);
      check("err_wptr", bus.wptr, m_wptr);
      check("err_valp", bus.valP, m_valp);
      check("err_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      check("err_once", 64'(bus.in_err), 64'd0);
      return;
    end
    model_image(ic, ifn, ra, rb, vc, start);
    m_wptr = start + 64'(n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (noise) begin
        bus.base_load = 1'b1;
        bus.base_addr = 64'($urandom_range(0, 1023));
        bus.in_valid  = 1'b1;
        bus.icode     = 4'($urandom_range(0, 15));
      end
      e = exp_q.pop_front();
      check("we", 64'(bus.mem_we), 64'd1);
      check("addr", bus.mem_addr, e[71:8]);
      check("wdata", 64'(bus.mem_wdata), 64'(e[7:0]));
      check("done", 64'(bus.instr_done), (k == n - 1) ? 64'd1 : 64'd0);
      check("busy", 64'(bus.in_ready), 64'd0);
      if (k == n - 1) check("valp", bus.valP, m_wptr);
    end
    m_valp = m_wptr;
    @(negedge clk);
    clear_inputs();
    check("ready_back", 64'(bus.in_ready), 64'd1);
    check("we_off", 64'(bus.mem_we), 64'd0);
    check("done_off", 64'(bus.instr_done), 64'd0);
    check("wptr_after", bus.wptr, m_wptr);
    check("valp_held", bus.valP, m_valp);
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  initial begin
    clear_inputs();
    m_wptr = 64'd0;
    m_valp = 64'd0;
    rst_n  = 1'b0;
    #12;
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    check("rst_we", 64'(bus.mem_we), 64'd0);
    check("rst_addr", bus.mem_addr, 64'd0);
    check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    check("rst_done", 64'(bus.instr_done), 64'd0);
    check("rst_err", 64'(bus.in_err), 64'd0);
    check("rst_wptr", bus.wptr, 64'd0);
    check("rst_valp", bus.valP, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 1'b0, 64'd0, 1'b0);
    send(4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 1'b1, 64'd32, 1'b0);
    send(4'h7, 4'h1, 4'h0, 4'h0, 64'h2D, 1'b0, 64'd0, 1'b0);
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0, 64'd0, 1'b0);
    send(4'hC, 4'h0, 4'h1, 4'h2, 64'd0, 1'b0, 64'd0, 1'b0);
    send(4'hA, 4'h0, 4'h4, 4'hF, 64'd0, 1'b0, 64'd0, 1'b1);
    send(4'h3, 4'h0, 4'hF, 4'h1, 64'hA5A5, 1'b1, 64'd1015, 1'b0);
    send(4'h3, 4'h0, 4'hF, 4'h1, 64'hDEADBEEFCAFEF00D, 1'b1, 64'd1014, 1'b0);
    check("top_valp", bus.valP, 64'd1024);
    send(4'h8, 4'h0, 4'h0, 4'h0, 64'h1122334455667788, 1'b1, 64'd1015, 1'b0);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0, 1'b0, 64'd0, 1'b0);

    // Abort mid-instruction with an asynchronous reset.
    bus.icode = 4'h4; bus.ifun = 4'h0; bus.rA = 4'h1; bus.rB = 4'h2;
    bus.valC = 64'h55; bus.base_load = 1'b1; bus.base_addr = 64'd100; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 clear_inputs();
    repeat (3) @(negedge clk);
    check("pre_rst_we", 64'(bus.mem_we), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_we", 64'(bus.mem_we), 64'd0);
    check("arst_wptr", bus.wptr, 64'd0);
    check("arst_ready", 64'(bus.in_ready), 64'd1);
    check("arst_valp", bus.valP, 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_wptr = 64'd0;
    m_valp = 64'd0;
    exp_q.delete();
    @(negedge clk);
    send(4'h6, 4'h1, 4'h5, 4'h6, 64'd0, 1'b0, 64'd0, 1'b0);

    for (int it = 0; it < 80; it++) begin
      logic [63:0] ba;
      logic bl;
      bl = ($urandom_range(0, 3) == 0) || (m_wptr > 64'd1010);
      ba = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(1005, 1023))
                                       : 64'($urandom_range(0, 300));
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), {$urandom, $urandom}, bl, ba, 1'($urandom_range(0, 1)));
    end

    summary();
    $finish;
  end
endmodule
